// File: rtl/ysyx_22040895_wbu_pkg.sv
// Shared encodings and helpers for the write-back unit: access kind, access size,
// default datapath width and the misalignment rule.
package ysyx_22040895_wbu_pkg;

    localparam int unsigned XLEN_DEF = 64;

    typedef enum logic [1:0] {
        SlAlu   = 2'b00,
        SlStore = 2'b01,
        SlLoad  = 2'b10
    } sl_e;

    typedef enum logic [1:0] {
        MuByte   = 2'b00,
        MuHalf   = 2'b01,
        MuWord   = 2'b10,
        MuDouble = 2'b11
    } munit_e;

    // Any memory access (sl != ALU) whose address is not a multiple of its size.
    function automatic logic is_misaligned(logic [1:0] sl, logic [1:0] munit, logic [2:0] addr_lo);
        logic r_mis;
        r_mis = 1'b0;
        if (sl != SlAlu) begin
            case (munit_e'(munit))
                MuByte:   r_mis = 1'b0;
                MuHalf:   r_mis = addr_lo[0];
                MuWord:   r_mis = |addr_lo[1:0];
                MuDouble: r_mis = |addr_lo;
                default:  r_mis = 1'b0;
            endcase
        end
        return r_mis;
    endfunction

endpackage

// File: rtl/ysyx_22040895_ldext.sv
// Load data formatter: extracts the addressed byte/half/word/double from a raw
// 8-byte aligned read and sign- or zero-extends it. Non-load data passes through.
module ysyx_22040895_ldext
    import ysyx_22040895_wbu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [1:0]      i_sl,
    input  logic [1:0]      i_munit,
    input  logic            i_unsigned,
    input  logic [2:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_data,
    output logic [XLEN-1:0] o_data
);

    logic [XLEN-1:0] w_shifted;

    assign w_shifted = i_data >> {i_addr_lo, 3'b000};

    always_comb begin
        o_data = i_data;
        if (i_sl == SlLoad) begin
            case (munit_e'(i_munit))
                MuByte: begin
                    o_data = i_unsigned ? {{(XLEN-8){1'b0}}, w_shifted[7:0]}
                                        : {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
                end
                MuHalf: begin
                    o_data = i_unsigned ? {{(XLEN-16){1'b0}}, w_shifted[15:0]}
                                        : {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
                end
                MuWord: begin
                    o_data = i_unsigned ? {{(XLEN-32){1'b0}}, w_shifted[31:0]}
                                        : {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
                end
                MuDouble: o_data = w_shifted;
                default:  o_data = i_data;
            endcase
        end
    end

endmodule

// File: rtl/ysyx_22040895_wbu.sv
// Write-back unit: small FIFO of memory-stage results, formatted at enqueue and
// retired one per cycle into the register file with a retire report and counter.
module ysyx_22040895_wbu
    import ysyx_22040895_wbu_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i_wbu,
    output logic            in_ready_o_wbu,
    input  logic [1:0]      sl_i_wbu,
    input  logic [1:0]      munit_i_wbu,
    input  logic            unsigned_i_wbu,
    input  logic [XLEN-1:0] addr_i_wbu,
    input  logic [XLEN-1:0] wdata_i_wbu,
    input  logic [4:0]      rd_i_wbu,
    input  logic            rwe_i_wbu,
    input  logic [XLEN-1:0] pc_i_wbu,
    input  logic            stall_i_wbu,
    input  logic            flush_i_wbu,
    output logic            rf_we_o_wbu,
    output logic [4:0]      rf_waddr_o_wbu,
    output logic [XLEN-1:0] rf_wdata_o_wbu,
    output logic            commit_valid_o_wbu,
    output logic [XLEN-1:0] commit_pc_o_wbu,
    output logic            misalign_o_wbu,
    output logic [63:0]     retire_cnt_o_wbu
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    // Entry payload; only r_valid is reset, the payload is qualified by it.
    logic [XLEN-1:0] r_data [DEPTH];
    logic [XLEN-1:0] r_pc   [DEPTH];
    logic [4:0]      r_dst  [DEPTH];
    logic            r_rwe  [DEPTH];
    logic            r_mis  [DEPTH];
    logic [DEPTH-1:0] r_valid;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [63:0]   r_retire_cnt;

    logic [XLEN-1:0] w_ld_data;
    logic            w_mis;
    logic            w_nonempty;
    logic            w_push;
    logic            w_pop;
    logic [PW-1:0]   w_wr_ptr_nxt;
    logic [PW-1:0]   w_rd_ptr_nxt;
    logic            w_unused_addr;

    assign w_unused_addr = ^addr_i_wbu[XLEN-1:3];

    ysyx_22040895_ldext #(
        .XLEN(XLEN)
    ) u_ldext (
        .i_sl      (sl_i_wbu),
        .i_munit   (munit_i_wbu),
        .i_unsigned(unsigned_i_wbu),
        .i_addr_lo (addr_i_wbu[2:0]),
        .i_data    (wdata_i_wbu),
        .o_data    (w_ld_data)
    );

    assign w_mis = is_misaligned(sl_i_wbu, munit_i_wbu, addr_i_wbu[2:0]);

    // No bypass when full: ready depends only on stored occupancy.
    assign in_ready_o_wbu = !rst && (r_count < DEPTH_C) && !flush_i_wbu;
    assign w_nonempty     = (r_count != '0) && r_valid[r_rd_ptr];
    assign w_push         = in_valid_i_wbu && in_ready_o_wbu;
    assign w_pop          = w_nonempty && !stall_i_wbu && !flush_i_wbu;

    assign w_wr_ptr_nxt = (r_wr_ptr == LAST_C) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (r_rd_ptr == LAST_C) ? '0 : r_rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wr_ptr] <= w_ld_data;
            r_pc[r_wr_ptr]   <= pc_i_wbu;
            r_dst[r_wr_ptr]  <= rd_i_wbu;
            r_rwe[r_wr_ptr]  <= rwe_i_wbu;
            r_mis[r_wr_ptr]  <= w_mis;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_valid      <= '0;
            r_retire_cnt <= '0;
        end else if (flush_i_wbu) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr           <= w_wr_ptr_nxt;
                r_valid[r_wr_ptr]  <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr           <= w_rd_ptr_nxt;
                r_valid[r_rd_ptr]  <= 1'b0;
                r_retire_cnt       <= r_retire_cnt + 64'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        rf_we_o_wbu        = 1'b0;
        rf_waddr_o_wbu     = '0;
        rf_wdata_o_wbu     = '0;
        commit_valid_o_wbu = 1'b0;
        commit_pc_o_wbu    = '0;
        misalign_o_wbu     = 1'b0;
        if (w_nonempty) begin
            rf_waddr_o_wbu = r_dst[r_rd_ptr];
            rf_wdata_o_wbu = r_data[r_rd_ptr];
        end
        if (w_pop) begin
            commit_valid_o_wbu = 1'b1;
            commit_pc_o_wbu    = r_pc[r_rd_ptr];
            misalign_o_wbu     = r_mis[r_rd_ptr];
            rf_we_o_wbu        = r_rwe[r_rd_ptr] && (r_dst[r_rd_ptr] != 5'd0)
                                 && !r_mis[r_rd_ptr];
        end
    end

    assign retire_cnt_o_wbu = r_retire_cnt;

endmodule

// File: tb/tb_ysyx_22040895_wbu.sv
// Directed bench for the write-back unit: load formatting, misalignment, stall/full,
// flush and asynchronous reset, each checked against hand-computed values.
module tb_ysyx_22040895_wbu;

    logic        clk;
    logic        rst;
    logic        in_valid_i_wbu;
    logic        in_ready_o_wbu;
    logic [1:0]  sl_i_wbu;
    logic [1:0]  munit_i_wbu;
    logic        unsigned_i_wbu;
    logic [63:0] addr_i_wbu;
    logic [63:0] wdata_i_wbu;
    logic [4:0]  rd_i_wbu;
    logic        rwe_i_wbu;
    logic [63:0] pc_i_wbu;
    logic        stall_i_wbu;
    logic        flush_i_wbu;
    logic        rf_we_o_wbu;
    logic [4:0]  rf_waddr_o_wbu;
    logic [63:0] rf_wdata_o_wbu;
    logic        commit_valid_o_wbu;
    logic [63:0] commit_pc_o_wbu;
    logic        misalign_o_wbu;
    logic [63:0] retire_cnt_o_wbu;

    int n_pass;
    int n_total;

    ysyx_22040895_wbu #(
        .XLEN (64),
        .DEPTH(2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid_i_wbu    (in_valid_i_wbu),
        .in_ready_o_wbu    (in_ready_o_wbu),
        .sl_i_wbu          (sl_i_wbu),
        .munit_i_wbu       (munit_i_wbu),
        .unsigned_i_wbu    (unsigned_i_wbu),
        .addr_i_wbu        (addr_i_wbu),
        .wdata_i_wbu       (wdata_i_wbu),
        .rd_i_wbu          (rd_i_wbu),
        .rwe_i_wbu         (rwe_i_wbu),
        .pc_i_wbu          (pc_i_wbu),
        .stall_i_wbu       (stall_i_wbu),
        .flush_i_wbu       (flush_i_wbu),
        .rf_we_o_wbu       (rf_we_o_wbu),
        .rf_waddr_o_wbu    (rf_waddr_o_wbu),
        .rf_wdata_o_wbu    (rf_wdata_o_wbu),
        .commit_valid_o_wbu(commit_valid_o_wbu),
        .commit_pc_o_wbu   (commit_pc_o_wbu),
        .misalign_o_wbu    (misalign_o_wbu),
        .retire_cnt_o_wbu  (retire_cnt_o_wbu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] sl, input logic [1:0] mu, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [4:0] rd, input logic rwe, input logic [63:0] pc);
        in_valid_i_wbu = 1'b1;
        sl_i_wbu       = sl;
        munit_i_wbu    = mu;
        unsigned_i_wbu = uns;
        addr_i_wbu     = addr;
        wdata_i_wbu    = wdata;
        rd_i_wbu       = rd;
        rwe_i_wbu      = rwe;
        pc_i_wbu       = pc;
    endtask

    initial begin
        n_pass         = 0;
        n_total        = 0;
        rst            = 1'b1;
        in_valid_i_wbu = 1'b0;
        sl_i_wbu       = 2'b00;
        munit_i_wbu    = 2'b00;
        unsigned_i_wbu = 1'b0;
        addr_i_wbu     = '0;
        wdata_i_wbu    = '0;
        rd_i_wbu       = '0;
        rwe_i_wbu      = 1'b0;
        pc_i_wbu       = '0;
        stall_i_wbu    = 1'b0;
        flush_i_wbu    = 1'b0;

        #2;
        chk("rst_in_ready", in_ready_o_wbu, 0);
        chk("rst_commit", commit_valid_o_wbu, 0);
        chk("rst_rf_we", rf_we_o_wbu, 0);
        chk("rst_retire", retire_cnt_o_wbu, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", in_ready_o_wbu, 1);

        // Signed byte load at offset 3
        drive(2'b10, 2'b00, 1'b0, 64'h80000003, 64'h0000_0000_80FF_0000, 5'd5, 1'b1,
              64'h80000100);
        tick();
        in_valid_i_wbu = 1'b0;
        #1;
        chk("lb_rf_we", rf_we_o_wbu, 1);
        chk("lb_waddr", rf_waddr_o_wbu, 5);
        chk("lb_wdata", rf_wdata_o_wbu, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_commit", commit_valid_o_wbu, 1);
        chk("lb_pc", commit_pc_o_wbu, 64'h80000100);
        chk("lb_mis", misalign_o_wbu, 0);
        tick();
        chk("lb_retire", retire_cnt_o_wbu, 1);
        chk("lb_empty", commit_valid_o_wbu, 0);

        // Unsigned half load at offset 6
        drive(2'b10, 2'b01, 1'b1, 64'h80000006, 64'hBEEF_0000_0000_0000, 5'd6, 1'b1,
              64'h80000104);
        tick();
        in_valid_i_wbu = 1'b0;
        #1;
        chk("lhu_wdata", rf_wdata_o_wbu, 64'h0000_0000_0000_BEEF);
        chk("lhu_rf_we", rf_we_o_wbu, 1);
        tick();

        // Signed word load at offset 4
        drive(2'b10, 2'b10, 1'b0, 64'h80000004, 64'h8765_4321_1234_5678, 5'd7, 1'b1,
              64'h80000108);
        tick();
        in_valid_i_wbu = 1'b0;
        #1;
        chk("lw_wdata", rf_wdata_o_wbu, 64'hFFFF_FFFF_8765_4321);
        tick();
        chk("lw_retire", retire_cnt_o_wbu, 3);

        // Misaligned word load
        drive(2'b10, 2'b10, 1'b0, 64'h80000002, 64'h1111_2222_3333_4444, 5'd8, 1'b1,
              64'h8000010C);
        tick();
        in_valid_i_wbu = 1'b0;
        #1;
        chk("mis_lw_flag", misalign_o_wbu, 1);
        chk("mis_lw_commit", commit_valid_o_wbu, 1);
        chk("mis_lw_rf_we", rf_we_o_wbu, 0);
        tick();
        chk("mis_lw_retire", retire_cnt_o_wbu, 4);

        // Misaligned double store
        drive(2'b01, 2'b11, 1'b0, 64'h80000004, 64'h0, 5'd0, 1'b0, 64'h80000110);
        tick();
        in_valid_i_wbu = 1'b0;
        #1;
        chk("mis_sd_flag", misalign_o_wbu, 1);
        chk("mis_sd_rf_we", rf_we_o_wbu, 0);
        tick();

        // Stall fills the buffer; release drains in order then takes the third push
        stall_i_wbu = 1'b1;
        drive(2'b00, 2'b00, 1'b0, 64'h0, 64'hA1, 5'd10, 1'b1, 64'h80000200);
        #1;
        chk("st_ready0", in_ready_o_wbu, 1);
        tick();
        drive(2'b00, 2'b00, 1'b0, 64'h0, 64'hA2, 5'd11, 1'b1, 64'h80000204);
        #1;
        chk("st_ready1", in_ready_o_wbu, 1);
        chk("st_no_commit", commit_valid_o_wbu, 0);
        tick();
        drive(2'b00, 2'b00, 1'b0, 64'h0, 64'hA3, 5'd12, 1'b1, 64'h80000208);
        #1;
        chk("st_full_ready", in_ready_o_wbu, 0);
        tick();
        stall_i_wbu = 1'b0;
        #1;
        chk("rel_ready", in_ready_o_wbu, 0);
        chk("rel_commit", commit_valid_o_wbu, 1);
        chk("rel_wdata1", rf_wdata_o_wbu, 64'hA1);
        chk("rel_waddr1", rf_waddr_o_wbu, 10);
        tick();
        chk("rel_ready2", in_ready_o_wbu, 1);
        chk("rel_wdata2", rf_wdata_o_wbu, 64'hA2);
        tick();
        in_valid_i_wbu = 1'b0;
        #1;
        chk("rel_wdata3", rf_wdata_o_wbu, 64'hA3);
        chk("rel_pc3", commit_pc_o_wbu, 64'h80000208);
        tick();
        chk("rel_drained", commit_valid_o_wbu, 0);
        chk("rel_retire", retire_cnt_o_wbu, 8);

        // Flush with two entries and a concurrent push
        stall_i_wbu = 1'b1;
        drive(2'b00, 2'b00, 1'b0, 64'h0, 64'hA4, 5'd13, 1'b1, 64'h80000300);
        tick();
        drive(2'b00, 2'b00, 1'b0, 64'h0, 64'hA5, 5'd14, 1'b1, 64'h80000304);
        tick();
        drive(2'b00, 2'b00, 1'b0, 64'h0, 64'hA6, 5'd15, 1'b1, 64'h80000308);
        flush_i_wbu = 1'b1;
        stall_i_wbu = 1'b0;
        #1;
        chk("fl_ready", in_ready_o_wbu, 0);
        chk("fl_commit", commit_valid_o_wbu, 0);
        chk("fl_rf_we", rf_we_o_wbu, 0);
        tick();
        flush_i_wbu    = 1'b0;
        in_valid_i_wbu = 1'b0;
        #1;
        chk("fl_empty", commit_valid_o_wbu, 0);
        chk("fl_waddr", rf_waddr_o_wbu, 0);
        chk("fl_ready_after", in_ready_o_wbu, 1);
        chk("fl_retire", retire_cnt_o_wbu, 8);
        tick();
        chk("fl_dropped", commit_valid_o_wbu, 0);

        // Asynchronous reset with one buffered entry
        stall_i_wbu = 1'b1;
        drive(2'b00, 2'b00, 1'b0, 64'h0, 64'hA7, 5'd16, 1'b1, 64'h80000400);
        tick();
        in_valid_i_wbu = 1'b0;
        #1;
        chk("ar_head", rf_waddr_o_wbu, 16);
        chk("ar_stalled", commit_valid_o_wbu, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_waddr", rf_waddr_o_wbu, 0);
        chk("ar_wdata", rf_wdata_o_wbu, 0);
        chk("ar_retire", retire_cnt_o_wbu, 0);
        chk("ar_ready", in_ready_o_wbu, 0);
        tick();
        tick();
        rst         = 1'b0;
        stall_i_wbu = 1'b0;
        #1;
        chk("ar_ready_after", in_ready_o_wbu, 1);
        chk("ar_discarded", commit_valid_o_wbu, 0);
        drive(2'b00, 2'b00, 1'b0, 64'h0, 64'hA8, 5'd0, 1'b1, 64'h80000500);
        tick();
        in_valid_i_wbu = 1'b0;
        #1;
        chk("x0_commit", commit_valid_o_wbu, 1);
        chk("x0_rf_we", rf_we_o_wbu, 0);
        chk("x0_pc", commit_pc_o_wbu, 64'h80000500);
        tick();
        chk("x0_retire", retire_cnt_o_wbu, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
